// File: rtl/vga_scanout_engine_if.sv
// Framebuffer, palette-write and buffer-swap bus between the scan-out
// engine (master) and the memory/CPU side (slave).
interface vga_scanout_engine_if #(
    parameter int ColorBits = 3,
    parameter int XW        = 9,
    parameter int YW        = 8
);
    logic [ColorBits-1:0] readValueMemory;
    logic [XW-1:0]        XRead;
    logic [YW-1:0]        YRead;
    logic                 fb_sel;
    logic                 swap_req;
    logic                 swap_ack;
    logic                 pal_we;
    logic [ColorBits-1:0] pal_addr;
    logic [23:0]          pal_data;

    modport master (
        input  readValueMemory, swap_req, pal_we, pal_addr, pal_data,
        output XRead, YRead, fb_sel, swap_ack
    );

    modport slave (
        output readValueMemory, swap_req, pal_we, pal_addr, pal_data,
        input  XRead, YRead, fb_sel, swap_ack
    );
endinterface

// File: rtl/vga_scanout_engine.sv
// VGA scan-out engine: pixel divider, h/v raster counters, framebuffer
// addressing with integer upscaling, palette lookup, registered sync/blank/RGB
// and frame-aligned double-buffer selection.
module vga_scanout_engine #(
    parameter int          ImageWidth   = 320,
    parameter int          ImageHeight  = 240,
    parameter int          ColorBits    = 3,
    parameter int          Scale        = 2,
    parameter int          PixelDivider = 2,
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic [23:0] BorderColor  = 24'h000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vga_scanout_engine_if.master bus,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 clkVGA,
    output logic                 vblank,
    output logic                 frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = $clog2(PixelDivider);
    localparam int XW       = $clog2(ImageWidth);
    localparam int YW       = $clog2(ImageHeight);
    localparam int SCALE_SH = $clog2(Scale);
    localparam int N_PAL    = 2 ** ColorBits;

    // The image region is clipped to the active area up front so one compare suffices.
    localparam int H_IMG_INT = (ImageWidth * Scale < H_ACTIVE) ? ImageWidth * Scale : H_ACTIVE;
    localparam int V_IMG_INT = (ImageHeight * Scale < V_ACTIVE) ? ImageHeight * Scale : V_ACTIVE;

    localparam logic [DW-1:0] D_LAST = DW'(PixelDivider - 1);
    localparam logic [DW-1:0] D_HALF = DW'(PixelDivider / 2);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_IMG  = HW'(H_IMG_INT);
    localparam logic [HW-1:0] H_SB   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_IMG  = VW'(V_IMG_INT);
    localparam logic [VW-1:0] V_SB   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          tick;
    logic          frame_end;
    logic          in_active;
    logic          in_image;
    logic          raw_hsync;
    logic          raw_vsync;
    logic [23:0]   pal_rd;
    logic [23:0]   palette [N_PAL];
    logic          fb_sel_r;
    logic          swap_ack_r;
    logic          pending;

    assign tick      = (div == D_LAST);
    assign frame_end = tick && (h == H_LAST) && (v == V_LAST);
    assign in_active = (h < H_ACT) && (v < V_ACT);
    assign in_image  = (h < H_IMG) && (v < V_IMG);
    assign raw_hsync = !((h >= H_SB) && (h < H_SE));
    assign raw_vsync = !((v >= V_SB) && (v < V_SE));
    assign vblank    = (v >= V_ACT);
    assign clkVGA    = (div >= D_HALF);

    // Framebuffer address: replicate each source pixel Scale times per axis.
    assign bus.XRead    = in_image ? XW'(h >> SCALE_SH) : '0;
    assign bus.YRead    = in_image ? YW'(v >> SCALE_SH) : '0;
    assign bus.fb_sel   = fb_sel_r;
    assign bus.swap_ack = swap_ack_r;

    // Stage 0: pixel divider and raster counters; h/v step once per tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick) begin
            div <= '0;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    // Palette registers: writes land on the next edge, reads are combinational.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PAL; i++) begin
                palette[i] <= {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
            end
        end else if (bus.pal_we) begin
            palette[bus.pal_addr] <= bus.pal_data;
        end
    end

    assign pal_rd = palette[bus.readValueMemory];

    // Stage 1: colour, syncs and blank captured together at the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync               <= 1'b1;
            vsync               <= 1'b1;
            blank               <= 1'b0;
            {red, green, blue}  <= 24'h0;
        end else if (tick) begin
            hsync <= raw_hsync;
            vsync <= raw_vsync;
            blank <= in_active;
            if (in_image) begin
                {red, green, blue} <= pal_rd;
            end else if (in_active) begin
                {red, green, blue} <= BorderColor;
            end else begin
                {red, green, blue} <= 24'h0;
            end
        end
    end

    // Frame pulse and buffer swap; a request seen at the wrap edge is kept for the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            fb_sel_r    <= 1'b0;
            swap_ack_r  <= 1'b0;
            pending     <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (frame_end && pending) begin
                fb_sel_r   <= ~fb_sel_r;
                swap_ack_r <= 1'b1;
                pending    <= bus.swap_req;
            end else begin
                swap_ack_r <= 1'b0;
                if (bus.swap_req) begin
                    pending <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout_engine.sv
// Directed bench for vga_scanout_engine using a reduced raster
// (24x12 ticks per frame) so several frames fit in a short run.
// dut_a: Scale=2, image covers the active area, PixelDivider=2.
// dut_b: Scale=1, image smaller than the active area, PixelDivider=4.
module tb_vga_scanout_engine;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;

    vga_scanout_engine_if #(.ColorBits(3), .XW(3), .YW(2)) bus_a ();
    vga_scanout_engine_if #(.ColorBits(3), .XW(3), .YW(2)) bus_b ();

    logic       hsync_a, vsync_a, blank_a, clkvga_a, vblank_a, fs_a;
    logic [7:0] r_a, g_a, b_a;
    logic       hsync_b, vsync_b, blank_b, clkvga_b, vblank_b, fs_b;
    logic [7:0] r_b, g_b, b_b;
    logic [23:0] rgb_a, rgb_b;

    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};

    vga_scanout_engine #(
        .ImageWidth(8), .ImageHeight(4), .ColorBits(3), .Scale(2), .PixelDivider(2),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .BorderColor(24'h000000)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a),
        .red(r_a), .green(g_a), .blue(b_a),
        .clkVGA(clkvga_a), .vblank(vblank_a), .frame_start(fs_a)
    );

    vga_scanout_engine #(
        .ImageWidth(8), .ImageHeight(4), .ColorBits(3), .Scale(1), .PixelDivider(4),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .BorderColor(24'hA5C3E7)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b),
        .red(r_b), .green(g_b), .blue(b_b),
        .clkVGA(clkvga_b), .vblank(vblank_b), .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    // Edge counter since the last reset release: edge k after release gives cyc == k.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Framebuffer contents: code = (5 + x + 3y + 2*sel) mod 8, so (0,0) of buffer 0 is 3'b101.
    function automatic logic [2:0] fb_code(input int x, input int y, input int sel);
        int t;
        t = 5 + x + 3 * y + 2 * sel;
        return t[2:0];
    endfunction

    // Synchronous-read framebuffer models, one per DUT.
    always @(posedge clk) begin
        bus_a.readValueMemory <= fb_code(int'(bus_a.XRead), int'(bus_a.YRead), int'(bus_a.fb_sel));
        bus_b.readValueMemory <= fb_code(int'(bus_b.XRead), int'(bus_b.YRead), int'(bus_b.fb_sel));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance to 1 time unit after edge k (relative to the last reset release).
    task automatic at_cyc(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != k) check("cycle_sync", cyc, k);
    endtask

    initial begin
        bus_a.swap_req = 1'b0; bus_a.pal_we = 1'b0; bus_a.pal_addr = '0; bus_a.pal_data = '0;
        bus_b.swap_req = 1'b0; bus_b.pal_we = 1'b0; bus_b.pal_addr = '0; bus_b.pal_data = '0;

        // Reset state
        #12;
        check("rst_hsync",  hsync_a, 1);
        check("rst_vsync",  vsync_a, 1);
        check("rst_blank",  blank_a, 0);
        check("rst_rgb",    rgb_a, 0);
        check("rst_clkvga", clkvga_a, 0);
        check("rst_xread",  bus_a.XRead, 0);
        check("rst_yread",  bus_a.YRead, 0);
        check("rst_fbsel",  bus_a.fb_sel, 0);
        check("rst_ack",    bus_a.swap_ack, 0);
        check("rst_fs",     fs_a, 0);
        check("rst_vblank", vblank_a, 0);
        #8;
        reset_n = 1'b1;

        // Pixel clock phase, first pixel, replication
        at_cyc(1);  check("clkvga_a_hi", clkvga_a, 1);
        at_cyc(2);  check("clkvga_a_lo", clkvga_a, 0);
                    check("clkvga_b_hi", clkvga_b, 1);
                    check("px00_rgb",    rgb_a, 24'hFF00FF);
                    check("px00_blank",  blank_a, 1);
        at_cyc(4);  check("xread_h2",    bus_a.XRead, 1);
                    check("clkvga_b_lo", clkvga_b, 0);
        at_cyc(12); check("b_px2_rgb",   rgb_b, 24'hFFFFFF);
        at_cyc(28); check("b_xread_h7",  bus_b.XRead, 7);
        at_cyc(34); check("porch_blank", blank_a, 0);
                    check("porch_rgb",   rgb_a, 0);
        at_cyc(36); check("hsync_h17",   hsync_a, 1);
        at_cyc(38); check("hsync_h18",   hsync_a, 0);
        at_cyc(40); check("b_xread_h10", bus_b.XRead, 0);
        at_cyc(42); check("hsync_h20",   hsync_a, 0);
        at_cyc(44); check("hsync_h21",   hsync_a, 1);
                    check("b_border",    rgb_b, 24'hA5C3E7);
        at_cyc(50); check("xread_h1v1",  bus_a.XRead, 0);
                    check("yread_h1v1",  bus_a.YRead, 0);
                    check("px01_rgb",    rgb_a, 24'hFF00FF);
        at_cyc(52); check("px11_rgb",    rgb_a, 24'hFF00FF);
        at_cyc(68); check("b_porch_blank", blank_b, 0);
        at_cyc(98); check("yread_v2",    bus_a.YRead, 1);
        at_cyc(288); check("b_yread_v3", bus_b.YRead, 3);
        at_cyc(382); check("vblank_v7",  vblank_a, 0);
        at_cyc(384); check("vblank_v8",  vblank_a, 1);
                     check("b_yread_v4", bus_b.YRead, 0);
        at_cyc(388); check("b_border_v4", rgb_b, 24'hA5C3E7);
        at_cyc(432); check("vsync_v8",   vsync_a, 1);
        at_cyc(434); check("vsync_v9",   vsync_a, 0);
        at_cyc(492); check("vsync_v10",  vsync_a, 0);
        at_cyc(530); check("vsync_v11",  vsync_a, 1);
        at_cyc(575); check("fs_before",  fs_a, 0);
        at_cyc(576); check("fs_frame1",  fs_a, 1);
        at_cyc(577); check("fs_after",   fs_a, 0);
        at_cyc(578); check("f1_px00_old_pal", rgb_a, 24'hFF00FF);

        // Palette write mid-line: entry 5 <= 123456
        at_cyc(600); bus_a.pal_we = 1'b1; bus_a.pal_addr = 3'd5; bus_a.pal_data = 24'h123456;
        at_cyc(601); bus_a.pal_we = 1'b0;
        at_cyc(690); check("pal_entry4", rgb_a, 24'hFF0000);
        at_cyc(694); check("pal_entry5", rgb_a, 24'h123456);

        // Two swap requests within frame 1 -> one swap at frame 2
        at_cyc(700); bus_a.swap_req = 1'b1;
        at_cyc(701); bus_a.swap_req = 1'b0;
        at_cyc(710); bus_a.swap_req = 1'b1;
        at_cyc(711); bus_a.swap_req = 1'b0;
        at_cyc(1151); check("fbsel_pre",  bus_a.fb_sel, 0);
                      check("ack_pre",    bus_a.swap_ack, 0);
        at_cyc(1152); check("fbsel_swap", bus_a.fb_sel, 1);
                      check("ack_swap",   bus_a.swap_ack, 1);
                      check("fs_frame2",  fs_a, 1);
        at_cyc(1153); check("ack_pulse",  bus_a.swap_ack, 0);
        at_cyc(1154); check("f2_px00_buf1", rgb_a, 24'hFFFFFF);
        at_cyc(1728); check("fbsel_single", bus_a.fb_sel, 1);
                      check("ack_none",   bus_a.swap_ack, 0);
                      check("fs_frame3",  fs_a, 1);

        // Request coincident with frame_start waits for the following frame
        bus_a.swap_req = 1'b1;
        at_cyc(1729); bus_a.swap_req = 1'b0;
                      check("fbsel_coinc_hold", bus_a.fb_sel, 1);
        at_cyc(2304); check("fbsel_coinc_swap", bus_a.fb_sel, 0);
                      check("ack_coinc",  bus_a.swap_ack, 1);
        at_cyc(2400); bus_a.swap_req = 1'b1;
        at_cyc(2401); bus_a.swap_req = 1'b0;
        at_cyc(2880); check("fbsel_f5",   bus_a.fb_sel, 1);

        // Pending request, then asynchronous reset mid-frame (h=10, v=5)
        at_cyc(3000); bus_a.swap_req = 1'b1;
        at_cyc(3001); bus_a.swap_req = 1'b0;
        at_cyc(3140); check("mid_xread", bus_a.XRead, 5);
                      check("mid_blank", blank_a, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_hsync", hsync_a, 1);
        check("arst_blank", blank_a, 0);
        check("arst_rgb",   rgb_a, 0);
        check("arst_xread", bus_a.XRead, 0);
        check("arst_yread", bus_a.YRead, 0);
        check("arst_fbsel", bus_a.fb_sel, 0);
        check("arst_vsync", vsync_a, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Restart from (0,0) with palette defaults and pending cleared
        at_cyc(2);   check("rs_px00_rgb", rgb_a, 24'hFF00FF);
        at_cyc(20);  check("rs_xread_h10", bus_a.XRead, 5);
        at_cyc(576); check("rs_fs",    fs_a, 1);
                     check("rs_fbsel", bus_a.fb_sel, 0);
                     check("rs_ack",   bus_a.swap_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
